issue_scoreboard: RTL and testbench
===================================

// Module: issue_scoreboard
// PURPOSE
//   Producer-side hazard tracker for the dual-issue pipeline: records the destination GPR and HI/LO
//   writes of in-flight instructions at issue and counts down the cycles until each result is forwardable.
//   Answers ready queries for the rs/rt of both issue candidates and raises the stall that holds id1_id2.
//   The forwarding unit then chooses the bypass source; this block only decides whether one exists yet.
// PARAMETERS
//   NUM_REGS  32  architectural GPR count; r0 is never tracked
//   CNT_W     4   width of each per-register countdown counter
//   HILO_LAT  8   cycles HI/LO stay busy after a divide issues (multiply uses the issue_hilo_lat value)
// PORTS
//   clk            in   1      clock, single domain; all state updates on rising edge
//   resetn         in   1      asynchronous reset, active-low
//   pipe_stall     in   1      pipeline freeze; counters hold, issues ignored
//   pipe_flush     in   1      exception/mispredict flush; clears all tracking
//   issue_ena_1    in   1      slot-1 instruction issues this cycle and writes a GPR
//   issue_dst_1    in   5      slot-1 destination register
//   issue_lat_1    in   CNT_W  slot-1 cycles until result forwardable (0=ALU, 1=load, ...)
//   issue_ena_2    in   1      slot-2 counterpart of issue_ena_1
//   issue_dst_2    in   5      slot-2 destination register
//   issue_lat_2    in   CNT_W  slot-2 latency
//   issue_hilo     in   1      an issuing instruction writes HI/LO
//   issue_hilo_div in   1      that write is a divide (use HILO_LAT)
//   issue_hilo_lat in   CNT_W  latency for non-divide HI/LO writes
//   id1_rs/id1_rt  in   5      source registers of candidate 1
//   id2_rs/id2_rt  in   5      source registers of candidate 2
//   id_rd_hilo_1   in   1      candidate 1 reads HI/LO
//   rs1_ready, rt1_ready, rs2_ready, rt2_ready  out 1  source forwardable or in regfile
//   hilo_busy      out  1      HI/LO counter non-zero
//   pair_dep       out  1      candidate 2 reads candidate 1's destination (must single-issue)
//   sb_stall_req   out  1      candidate 1 not ready: stall id1_id2
// BEHAVIOUR
//   - Reset: all counters 0; every *_ready=1, hilo_busy=0, pair_dep=0, sb_stall_req=0.
//   - State: cnt[1..NUM_REGS-1] (CNT_W bits), hilo_cnt (CNT_W bits). cnt==0 means ready.
//   - Per cycle priority: pipe_flush > pipe_stall > issue write > decrement.
//   - pipe_flush=1: all cnt and hilo_cnt <= 0 next edge, issues in same cycle discarded.
//   - pipe_stall=1 (no flush): all counters hold; issue_* ignored.
//   - Otherwise each non-zero counter decrements by 1 (saturate at 0, never wraps).
//   - Issue write: cnt[dst] <= lat, overriding decrement. dst==0 ignored. Both slots same dst: slot 2 wins.
//   - HI/LO: issue_hilo -> hilo_cnt <= issue_hilo_div ? HILO_LAT : issue_hilo_lat; HILO_LAT truncated to CNT_W.
//   - rsN_ready/rtN_ready = (reg==0) | (cnt[reg]==0); pure function of registered state, no
//     combinational path from issue_* to *_ready (issuing lat 0 is ready next cycle).
//   - pair_dep = issue_dst_1!=0 & (id2_rs==issue_dst_1 | id2_rt==issue_dst_1) & issue_ena_1.
//   - sb_stall_req = ~rs1_ready | ~rt1_ready | (id_rd_hilo_1 & hilo_busy); 0 while pipe_flush=1.
//   - Reset mid-operation: asserting resetn=0 clears everything immediately (async), no pending state.
// STRUCTURE
//   - Shared header gemini_sb_defs.vh: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=2, HILO_DIV_LAT default.
//   - One sub-module natural: sb_counter (CNT_W countdown with load/hold/clear), instantiated
//     NUM_REGS-1 times plus once for HI/LO; top holds decode, write-priority and query muxes.
// TESTING
//   - Reset: resetn=0 then 1, query r5 -> all *_ready=1, sb_stall_req=0, hilo_busy=0.
//   - Load-use: issue_ena_1, dst=8, lat=1; next cycle id1_rs=8 -> rs1_ready=0, sb_stall_req=1; cycle after -> 1/0.
//   - Same-dst dual issue: slot1 dst=4 lat=3, slot2 dst=4 lat=0 -> next cycle id1_rt=4 ready=1.
//   - Stall hold: dst=9 lat=2, pipe_stall=1 for 3 cycles -> rs ready stays 0; ready 2 cycles after release.
//   - Flush: dst=10 lat=5 and simultaneous flush+issue dst=11 -> next cycle both r10,r11 ready=1.
//   - HI/LO divide: issue_hilo_div -> hilo_busy=1 for exactly HILO_LAT cycles; id_rd_hilo_1 stalls until then;
//     pair_dep=1 for issue_dst_1=7,id2_rt=7; r0 never busy (dst=0 lat=3 -> id1_rs=0 ready=1).

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: default geometry and the
// per-class result latencies used by the issue stage.
package issue_scoreboard_pkg;

  localparam int SB_NUM_REGS  = 32;
  localparam int SB_CNT_W     = 4;
  localparam int SB_HILO_LAT  = 8;
  localparam int SB_REG_W     = 5;

  // Cycles from issue until the result can be bypassed.
  localparam int LAT_ALU      = 0;
  localparam int LAT_LOAD     = 1;
  localparam int LAT_MUL      = 2;
  localparam int HILO_DIV_LAT = SB_HILO_LAT;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Issue / query bundle between the dual-issue front end and the scoreboard.
// Handshake: issue_ena_N and issue_hilo are single-cycle qualifiers sampled on
// the rising edge; there is no back-pressure on them other than pipe_stall,
// which makes the scoreboard ignore that cycle's issues entirely.
interface issue_scoreboard_if
  import issue_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
);
  logic                pipe_stall;
  logic                pipe_flush;
  logic                issue_ena_1;
  logic [SB_REG_W-1:0] issue_dst_1;
  logic [CNT_W-1:0]    issue_lat_1;
  logic                issue_ena_2;
  logic [SB_REG_W-1:0] issue_dst_2;
  logic [CNT_W-1:0]    issue_lat_2;
  logic                issue_hilo;
  logic                issue_hilo_div;
  logic [CNT_W-1:0]    issue_hilo_lat;
  logic [SB_REG_W-1:0] id1_rs;
  logic [SB_REG_W-1:0] id1_rt;
  logic [SB_REG_W-1:0] id2_rs;
  logic [SB_REG_W-1:0] id2_rt;
  logic                id_rd_hilo_1;
  logic                rs1_ready;
  logic                rt1_ready;
  logic                rs2_ready;
  logic                rt2_ready;
  logic                hilo_busy;
  logic                pair_dep;
  logic                sb_stall_req;

  // Pipeline side: drives issues and queries, receives readiness.
  modport master (
    output pipe_stall, pipe_flush,
    output issue_ena_1, issue_dst_1, issue_lat_1,
    output issue_ena_2, issue_dst_2, issue_lat_2,
    output issue_hilo, issue_hilo_div, issue_hilo_lat,
    output id1_rs, id1_rt, id2_rs, id2_rt, id_rd_hilo_1,
    input  rs1_ready, rt1_ready, rs2_ready, rt2_ready,
    input  hilo_busy, pair_dep, sb_stall_req
  );

  // Scoreboard side.
  modport slave (
    input  pipe_stall, pipe_flush,
    input  issue_ena_1, issue_dst_1, issue_lat_1,
    input  issue_ena_2, issue_dst_2, issue_lat_2,
    input  issue_hilo, issue_hilo_div, issue_hilo_lat,
    input  id1_rs, id1_rt, id2_rs, id2_rt, id_rd_hilo_1,
    output rs1_ready, rt1_ready, rs2_ready, rt2_ready,
    output hilo_busy, pair_dep, sb_stall_req
  );
endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// Saturating countdown counter for one tracked result.
// Priority: clear > hold > load > decrement; zero means "forwardable".
module sb_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             hold,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: flush wins, stall freezes, issue overrides the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Producer-side hazard tracker for the dual-issue pipeline. One countdown per
// GPR (r0 excluded) plus one for HI/LO; readiness is derived from registered
// counts only, so an issue never affects *_ready in the same cycle.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int CNT_W    = SB_CNT_W,
  parameter int HILO_LAT = SB_HILO_LAT
) (
  input  logic                 clk,
  input  logic                 resetn,
  issue_scoreboard_if.slave    sb
);

  // Divide latency is deliberately truncated to the counter width.
  localparam logic [CNT_W-1:0] HILO_LAT_T = CNT_W'(HILO_LAT);

  logic [CNT_W-1:0] cnt_all [NUM_REGS];
  logic [CNT_W-1:0] hilo_cnt;

  // r0 is hard-wired ready.
  assign cnt_all[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic             hit1;
    logic             hit2;
    logic [CNT_W-1:0] wr_val;

    assign hit1   = sb.issue_ena_1 && (sb.issue_dst_1 == SB_REG_W'(r));
    assign hit2   = sb.issue_ena_2 && (sb.issue_dst_2 == SB_REG_W'(r));
    // Slot 2 is younger, so its latency wins on a shared destination.
    assign wr_val = hit2 ? sb.issue_lat_2 : sb.issue_lat_1;

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (sb.pipe_flush),
      .hold     (sb.pipe_stall),
      .load     (hit1 || hit2),
      .load_val (wr_val),
      .cnt      (cnt_all[r])
    );
  end

  sb_counter #(.CNT_W(CNT_W)) u_hilo_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (sb.pipe_flush),
    .hold     (sb.pipe_stall),
    .load     (sb.issue_hilo),
    .load_val (sb.issue_hilo_div ? HILO_LAT_T : sb.issue_hilo_lat),
    .cnt      (hilo_cnt)
  );

  // Source readiness: r0 or a drained counter.
  assign sb.rs1_ready = (sb.id1_rs == '0) || (cnt_all[sb.id1_rs] == '0);
  assign sb.rt1_ready = (sb.id1_rt == '0) || (cnt_all[sb.id1_rt] == '0);
  assign sb.rs2_ready = (sb.id2_rs == '0) || (cnt_all[sb.id2_rs] == '0);
  assign sb.rt2_ready = (sb.id2_rt == '0) || (cnt_all[sb.id2_rt] == '0);
  assign sb.hilo_busy = (hilo_cnt != '0);

  // Candidate 2 consuming candidate 1's destination forces single issue.
  assign sb.pair_dep = sb.issue_ena_1 && (sb.issue_dst_1 != '0) &&
                       ((sb.id2_rs == sb.issue_dst_1) || (sb.id2_rt == sb.issue_dst_1));

  // A flushing cycle never stalls: the candidates are being discarded anyway.
  assign sb.sb_stall_req = !sb.pipe_flush &&
                           (!sb.rs1_ready || !sb.rt1_ready ||
                            (sb.id_rd_hilo_1 && sb.hilo_busy));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: one task per scenario, inline checks.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  issue_scoreboard_if #(.CNT_W(SB_CNT_W)) sb_if ();

  issue_scoreboard dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle_inputs();
    sb_if.pipe_stall     = 1'b0;
    sb_if.pipe_flush     = 1'b0;
    sb_if.issue_ena_1    = 1'b0;
    sb_if.issue_dst_1    = '0;
    sb_if.issue_lat_1    = '0;
    sb_if.issue_ena_2    = 1'b0;
    sb_if.issue_dst_2    = '0;
    sb_if.issue_lat_2    = '0;
    sb_if.issue_hilo     = 1'b0;
    sb_if.issue_hilo_div = 1'b0;
    sb_if.issue_hilo_lat = '0;
    sb_if.id1_rs         = '0;
    sb_if.id1_rt         = '0;
    sb_if.id2_rs         = '0;
    sb_if.id2_rt         = '0;
    sb_if.id_rd_hilo_1   = 1'b0;
  endtask

  // Advance one clock; inputs may change right after, outputs settle by +2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue1(input logic [4:0] dst, input logic [3:0] lat);
    sb_if.issue_ena_1 = 1'b1;
    sb_if.issue_dst_1 = dst;
    sb_if.issue_lat_1 = lat;
  endtask

  task automatic clear_issue();
    sb_if.issue_ena_1 = 1'b0;
    sb_if.issue_ena_2 = 1'b0;
    sb_if.issue_hilo  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    sb_if.id1_rs = 5'd5; sb_if.id1_rt = 5'd5; sb_if.id2_rs = 5'd5; sb_if.id2_rt = 5'd5;
    sb_if.id_rd_hilo_1 = 1'b1;
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.rt1_ready, sb_if.rs2_ready, sb_if.rt2_ready} !== 4'b1111) begin
      n_errors++;
      $display("FAIL reset_ready: got %b expected 1111",
               {sb_if.rs1_ready, sb_if.rt1_ready, sb_if.rs2_ready, sb_if.rt2_ready});
    end
    n_checks++;
    if ({sb_if.sb_stall_req, sb_if.hilo_busy, sb_if.pair_dep} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: stall/hilo/pair got %b expected 000",
               {sb_if.sb_stall_req, sb_if.hilo_busy, sb_if.pair_dep});
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    tick();
    issue1(5'd8, 4'(LAT_LOAD));
    tick();
    clear_issue();
    sb_if.id1_rs = 5'd8;
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.sb_stall_req} !== 2'b01) begin
      n_errors++;
      $display("FAIL load_use_busy: ready/stall got %b expected 01",
               {sb_if.rs1_ready, sb_if.sb_stall_req});
    end
    tick();
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.sb_stall_req} !== 2'b10) begin
      n_errors++;
      $display("FAIL load_use_ready: ready/stall got %b expected 10",
               {sb_if.rs1_ready, sb_if.sb_stall_req});
    end
    idle_inputs();
  endtask

  task automatic test_same_dst();
    tick();
    issue1(5'd4, 4'd3);
    sb_if.issue_ena_2 = 1'b1;
    sb_if.issue_dst_2 = 5'd4;
    sb_if.issue_lat_2 = 4'(LAT_ALU);
    // Issue alone must not change readiness within the same cycle.
    sb_if.id1_rt = 5'd4;
    settle();
    n_checks++;
    if (sb_if.rt1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_issue: rt1_ready got %b expected 1", sb_if.rt1_ready);
    end
    tick();
    clear_issue();
    settle();
    n_checks++;
    if (sb_if.rt1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL same_dst_slot2_wins: rt1_ready got %b expected 1", sb_if.rt1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    tick();
    issue1(5'd9, 4'd2);
    tick();
    clear_issue();
    sb_if.id1_rs     = 5'd9;
    sb_if.id2_rs     = 5'd12;
    sb_if.pipe_stall = 1'b1;
    // Issue during stall must be ignored.
    issue1(5'd12, 4'd3);
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (sb_if.rs1_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold cycle %0d: rs1_ready got %b expected 0", i, sb_if.rs1_ready);
      end
      tick();
    end
    clear_issue();
    sb_if.pipe_stall = 1'b0;
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.rs2_ready} !== 2'b01) begin
      n_errors++;
      $display("FAIL stall_release: rs1/rs2 got %b expected 01", {sb_if.rs1_ready, sb_if.rs2_ready});
    end
    tick();
    settle();
    n_checks++;
    if (sb_if.rs1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_release_plus1: rs1_ready got %b expected 0", sb_if.rs1_ready);
    end
    tick();
    settle();
    n_checks++;
    if (sb_if.rs1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release_plus2: rs1_ready got %b expected 1", sb_if.rs1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    tick();
    issue1(5'd10, 4'd5);
    tick();
    issue1(5'd11, 4'd5);
    sb_if.pipe_flush = 1'b1;
    sb_if.id1_rs     = 5'd10;
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.sb_stall_req} !== 2'b00) begin
      n_errors++;
      $display("FAIL flush_stall_mask: ready/stall got %b expected 00",
               {sb_if.rs1_ready, sb_if.sb_stall_req});
    end
    tick();
    clear_issue();
    sb_if.pipe_flush = 1'b0;
    sb_if.id1_rt     = 5'd11;
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.rt1_ready, sb_if.sb_stall_req} !== 3'b110) begin
      n_errors++;
      $display("FAIL flush_clear: rs1/rt1/stall got %b expected 110",
               {sb_if.rs1_ready, sb_if.rt1_ready, sb_if.sb_stall_req});
    end
    idle_inputs();
  endtask

  task automatic test_hilo();
    int busy_cycles;
    tick();
    sb_if.issue_hilo     = 1'b1;
    sb_if.issue_hilo_div = 1'b1;
    sb_if.issue_hilo_lat = 4'd1;
    tick();
    clear_issue();
    sb_if.id_rd_hilo_1 = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      settle();
      if (sb_if.hilo_busy !== 1'b1) break;
      n_checks++;
      if (sb_if.sb_stall_req !== 1'b1) begin
        n_errors++;
        $display("FAIL hilo_stall cycle %0d: stall got %b expected 1", i, sb_if.sb_stall_req);
      end
      busy_cycles++;
      tick();
    end
    n_checks++;
    if (busy_cycles != HILO_DIV_LAT) begin
      n_errors++;
      $display("FAIL hilo_div_len: busy cycles got %0d expected %0d", busy_cycles, HILO_DIV_LAT);
    end
    n_checks++;
    if (sb_if.sb_stall_req !== 1'b0) begin
      n_errors++;
      $display("FAIL hilo_done_stall: stall got %b expected 0", sb_if.sb_stall_req);
    end
    // Multiply path uses the supplied latency.
    tick();
    sb_if.issue_hilo     = 1'b1;
    sb_if.issue_hilo_div = 1'b0;
    sb_if.issue_hilo_lat = 4'(LAT_MUL);
    tick();
    clear_issue();
    sb_if.id_rd_hilo_1 = 1'b0;
    settle();
    n_checks++;
    if ({sb_if.hilo_busy, sb_if.sb_stall_req} !== 2'b10) begin
      n_errors++;
      $display("FAIL hilo_mul_busy: busy/stall got %b expected 10", {sb_if.hilo_busy, sb_if.sb_stall_req});
    end
    repeat (2) tick();
    settle();
    n_checks++;
    if (sb_if.hilo_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL hilo_mul_done: busy got %b expected 0", sb_if.hilo_busy);
    end
    idle_inputs();
  endtask

  task automatic test_pair_dep_r0();
    tick();
    issue1(5'd7, 4'd0);
    sb_if.id2_rt = 5'd7;
    settle();
    n_checks++;
    if (sb_if.pair_dep !== 1'b1) begin
      n_errors++;
      $display("FAIL pair_dep_hit: got %b expected 1", sb_if.pair_dep);
    end
    sb_if.issue_ena_1 = 1'b0;
    settle();
    n_checks++;
    if (sb_if.pair_dep !== 1'b0) begin
      n_errors++;
      $display("FAIL pair_dep_no_ena: got %b expected 0", sb_if.pair_dep);
    end
    issue1(5'd0, 4'd3);
    sb_if.id2_rt = 5'd0;
    settle();
    n_checks++;
    if (sb_if.pair_dep !== 1'b0) begin
      n_errors++;
      $display("FAIL pair_dep_r0: got %b expected 0", sb_if.pair_dep);
    end
    tick();
    clear_issue();
    sb_if.id1_rs = 5'd0;
    settle();
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.sb_stall_req} !== 2'b10) begin
      n_errors++;
      $display("FAIL r0_never_busy: ready/stall got %b expected 10",
               {sb_if.rs1_ready, sb_if.sb_stall_req});
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    tick();
    issue1(5'd6, 4'd3);
    tick();
    issue1(5'd6, 4'd1);
    tick();
    clear_issue();
    sb_if.id2_rs = 5'd6;
    settle();
    n_checks++;
    if (sb_if.rs2_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reissue_busy: rs2_ready got %b expected 0", sb_if.rs2_ready);
    end
    tick();
    settle();
    n_checks++;
    if (sb_if.rs2_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reissue_override: rs2_ready got %b expected 1", sb_if.rs2_ready);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    tick();
    issue1(5'd13, 4'd5);
    tick();
    clear_issue();
    sb_if.id1_rs = 5'd13;
    settle();
    n_checks++;
    if (sb_if.rs1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL async_pre: rs1_ready got %b expected 0", sb_if.rs1_ready);
    end
    #1;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({sb_if.rs1_ready, sb_if.sb_stall_req} !== 2'b10) begin
      n_errors++;
      $display("FAIL async_reset_clear: ready/stall got %b expected 10",
               {sb_if.rs1_ready, sb_if.sb_stall_req});
    end
    tick();
    resetn = 1'b1;
    tick();
    idle_inputs();
  endtask

  // Sequencer and final report
  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn   = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_same_dst();
    test_stall_hold();
    test_flush();
    test_hilo();
    test_pair_dep_r0();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
